// File: rtl/maxpool_reduce.sv
// Streaming max-pool: keeps the running signed maximum of each patch read from the
// feature map and writes it to the output map when the next patch starts or the image ends.
module maxpool_reduce #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 19
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              maxpool_enable,
  input  logic              patch_end,
  input  logic              maxpool_done,
  input  logic [DATA_W-1:0] rd_data,
  input  logic [ADDR_W-1:0] wr_base,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic [ADDR_W-1:0] pool_count,
  output logic              pool_done
);

  typedef enum logic [1:0] {IDLE, ACCUM, FLUSH, DONE} state_t;

  state_t             state;
  logic               en_d, pe_d, dn_d;
  logic               has_data;
  logic [DATA_W-1:0]  cur_max;
  logic [ADDR_W-1:0]  wr_ptr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      en_d       <= 1'b0;
      pe_d       <= 1'b0;
      dn_d       <= 1'b0;
      has_data   <= 1'b0;
      cur_max    <= '0;
      wr_ptr     <= '0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      pool_count <= '0;
      pool_done  <= 1'b0;
    end else begin
      // Control strobes lag one cycle so they line up with the RAM read data.
      en_d  <= maxpool_enable;
      pe_d  <= patch_end;
      dn_d  <= maxpool_done;
      wr_en <= 1'b0;

      case (state)
        IDLE: begin
          pool_done <= 1'b0;
          if (en_d) begin
            state      <= ACCUM;
            wr_ptr     <= wr_base;
            cur_max    <= rd_data;
            has_data   <= 1'b1;
            pool_count <= '0;
          end
        end

        ACCUM: begin
          if (dn_d) begin
            // The final write is launched on entry to FLUSH so it lands two cycles
            // after maxpool_done, same as a patch_end write; the dn_d sample itself is dropped.
            state <= FLUSH;
            if (has_data) begin
              wr_en      <= 1'b1;
              wr_addr    <= wr_ptr;
              wr_data    <= cur_max;
              pool_count <= pool_count + ADDR_W'(1);
              has_data   <= 1'b0;
            end
          end else if (en_d) begin
            if (pe_d) begin
              wr_en      <= 1'b1;
              wr_addr    <= wr_ptr;
              wr_data    <= cur_max;
              wr_ptr     <= wr_ptr + ADDR_W'(1);
              pool_count <= pool_count + ADDR_W'(1);
              cur_max    <= rd_data;
            end else if ($signed(rd_data) > $signed(cur_max)) begin
              cur_max <= rd_data;
            end
          end
        end

        FLUSH: begin
          state     <= DONE;
          pool_done <= 1'b1;
        end

        DONE: begin
          if (!maxpool_enable) begin
            state     <= IDLE;
            pool_done <= 1'b0;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_maxpool_reduce.sv
// Randomized bench for maxpool_reduce against a sample-stream model of patch maxima.
module tb_maxpool_reduce;
  localparam int DW = 16;
  localparam int AW = 19;
  localparam int AMASK = (1 << AW) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          maxpool_enable, patch_end, maxpool_done;
  logic [DW-1:0] rd_data;
  logic [AW-1:0] wr_base;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [AW-1:0] pool_count;
  logic          pool_done;

  maxpool_reduce #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .maxpool_enable(maxpool_enable), .patch_end(patch_end),
    .maxpool_done(maxpool_done), .rd_data(rd_data), .wr_base(wr_base), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .pool_count(pool_count), .pool_done(pool_done)
  );

  always #5 clk = ~clk;

  typedef struct {int cyc; int addr; int data;} wr_t;
  wr_t obs_q[$];
  wr_t exp_q[$];
  int  samples[$];
  int  cyc = 0;
  int  pend = 0;
  int  nvec = 0;
  int  nerr = 0;

  // Model: the stream of issued samples, grouped into patches.
  int  m_phase;   // 0 waiting for first sample, 1 inside image, 2 image ended
  int  m_cur, m_addr, m_count;

  always @(negedge clk)
    if (wr_en === 1'b1) obs_q.push_back('{cyc, int'(wr_addr), int'(wr_data)});

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_issue(input bit en, input bit pe, input bit dn, input int smp, input int c);
    wr_t w;
    if (!en || m_phase == 2) return;
    if (m_phase == 0) begin
      m_cur = smp;
      m_phase = 1;
    end else if (dn || pe) begin
      w = '{c + 2, m_addr, m_cur & 16'hFFFF};
      exp_q.push_back(w);
      m_count = (m_count + 1) & AMASK;
      if (dn) m_phase = 2;
      else begin
        m_addr = (m_addr + 1) & AMASK;
        m_cur = smp;
      end
    end else if (smp > m_cur) begin
      m_cur = smp;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Inputs driven here belong to the current cycle; rd_data answers the previous cycle's address.
  task automatic drive(input bit en, input bit pe, input bit dn, input int smp);
    step();
    rd_data        = DW'(pend);
    maxpool_enable = en;
    patch_end      = pe;
    maxpool_done   = dn;
    pend           = smp;
    model_issue(en, pe, dn, smp, cyc);
  endtask

  function automatic int junk();
    return $urandom_range(0, 65535) - 32768;
  endfunction

  task automatic run_job(input int base, input int psize, input int stall_pct, input bit combine);
    int n;
    obs_q.delete();
    exp_q.delete();
    m_phase = 0;
    m_addr  = base & AMASK;
    m_count = 0;
    wr_base = AW'(base);
    for (int i = 0; i < samples.size(); i++) begin
      if (i > 0 && $urandom_range(0, 99) < stall_pct)
        repeat ($urandom_range(1, 3)) drive(1'b0, 1'b0, 1'b0, junk());
      drive(1'b1, (i % psize) == 0, 1'b0, samples[i]);
    end
    drive(1'b1, combine, 1'b1, junk());
    repeat (2) drive(1'b1, 1'b0, 1'b1, junk());
    drive(1'b1, 1'b0, 1'b0, junk());
    @(negedge clk);
    check("pool_done_hi", {31'b0, pool_done}, 32'd1);
    check("pool_count", {13'b0, pool_count}, m_count);
    drive(1'b0, 1'b0, 1'b0, junk());
    drive(1'b0, 1'b0, 1'b0, junk());
    @(negedge clk);
    check("pool_done_lo", {31'b0, pool_done}, 32'd0);
    check("n_writes", obs_q.size(), exp_q.size());
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check("wr_addr", obs_q[i].addr, exp_q[i].addr);
      check("wr_data", obs_q[i].data, exp_q[i].data);
      check("wr_cycle", obs_q[i].cyc, exp_q[i].cyc);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    @(negedge clk);
    check({tag, "_wr_en"}, {31'b0, wr_en}, 32'd0);
    check({tag, "_wr_addr"}, {13'b0, wr_addr}, 32'd0);
    check({tag, "_wr_data"}, {16'b0, wr_data}, 32'd0);
    check({tag, "_pool_count"}, {13'b0, pool_count}, 32'd0);
    check({tag, "_pool_done"}, {31'b0, pool_done}, 32'd0);
  endtask

  initial begin
    int v, np, ps;
    reset = 1'b1;
    maxpool_enable = 1'b0;
    patch_end = 1'b0;
    maxpool_done = 1'b0;
    rd_data = '0;
    wr_base = '0;
    repeat (3) step();
    check_reset_outputs("rst");
    reset = 1'b0;
    repeat (2) drive(1'b0, 1'b0, 1'b0, 0);

    samples = '{3, -7, 9, 2, -1, -4, -2, -8};
    run_job(32'h100, 4, 0, 1'b0);
    samples = '{-32768, -32768, -32768, -32768, 5, 5, 5, 5};
    run_job(32'h200, 4, 0, 1'b0);
    samples = '{1, 2, 3, 4};
    run_job(32'h300, 4, 0, 1'b1);
    samples = '{6, 1, 2, 8};
    run_job(32'h040, 4, 100, 1'b0);
    samples = '{7, 3, 9, 1, 4, 4};
    run_job(AMASK, 2, 0, 1'b0);

    // Abort mid-patch: nothing of the partial patch may be written afterwards.
    obs_q.delete();
    wr_base = AW'(5);
    drive(1'b1, 1'b1, 1'b0, 7);
    drive(1'b1, 1'b0, 1'b0, 9);
    reset = 1'b1;
    pend = 0;
    drive(1'b0, 1'b0, 1'b0, 0);
    check_reset_outputs("midrst");
    reset = 1'b0;
    repeat (3) drive(1'b0, 1'b0, 1'b0, 0);
    @(negedge clk);
    check("post_reset_nowr", obs_q.size(), 0);
    samples = '{2, 1, 0, 1};
    run_job(0, 4, 0, 1'b0);

    for (int j = 0; j < 30; j++) begin
      ps = $urandom_range(1, 4);
      np = $urandom_range(1, 5);
      samples.delete();
      for (int k = 0; k < ps * np; k++) begin
        case ($urandom_range(0, 9))
          0, 1:    v = -32768;
          2:       v = 32767;
          3, 4:    v = (k > 0) ? samples[k-1] : 0;
          default: v = junk();
        endcase
        samples.push_back(v);
      end
      run_job($urandom_range(0, AMASK), ps, 30, 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
